// File: rtl/mips32_pkg.sv
// Shared types and constants for the mips32 program loader.
// The header word carries the load base address in its upper half and the word count in its lower half.
package mips32_pkg;

    typedef enum logic [2:0] {
        HDR   = 3'd0,
        DATA  = 3'd1,
        START = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } loader_state_t;

    localparam int LDR_HDR_BASE_MSB  = 31;
    localparam int LDR_HDR_BASE_LSB  = 16;
    localparam int LDR_HDR_COUNT_MSB = 15;
    localparam int LDR_HDR_COUNT_LSB = 0;
    localparam int LDR_CNT_W         = 16;

    localparam logic [5:0] HLT_OPCODE = 6'h3f;

endpackage

// File: rtl/mips32_prog_loader_if.sv
// Byte-stream input, memory write port and core-control outputs of the program loader.
interface mips32_prog_loader_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    import mips32_pkg::*;

    // A byte moves on a rising clk1 edge when in_valid && in_ready; the source holds
    // in_data stable while in_valid is high, and in_ready never depends on in_valid.
    logic                 in_valid;
    logic [7:0]           in_data;
    logic                 in_ready;
    logic                 load_req;
    logic                 mem_we;
    logic [ADDR_W-1:0]    mem_addr;
    logic [DATA_W-1:0]    mem_wdata;
    logic                 cpu_hold;
    logic                 cpu_start;
    logic                 busy;
    logic                 done;
    logic                 err;
    logic [LDR_CNT_W-1:0] words_loaded;
    loader_state_t        dbg_state;

    modport master (
        input  in_valid, in_data, load_req,
        output in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, cpu_start,
               busy, done, err, words_loaded, dbg_state
    );

    modport slave (
        output in_valid, in_data, load_req,
        input  in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, cpu_start,
               busy, done, err, words_loaded, dbg_state
    );

endinterface

// File: rtl/mips32_byte_packer.sv
// Big-endian byte-to-word packer: four accepted bytes form one 32-bit word.
// The completed word is presented combinationally in the cycle of its 4th byte.
module mips32_byte_packer (
    input  logic        clk1,
    input  logic        clear_i,
    input  logic        accept_i,
    input  logic [7:0]  byte_i,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    logic [1:0]  cnt_q;
    logic [23:0] word_q;

    assign word_o       = {word_q, byte_i};
    assign word_valid_o = accept_i && (cnt_q == 2'd3);

    always_ff @(posedge clk1) begin
        if (clear_i) begin
            cnt_q  <= 2'd0;
            word_q <= '0;
        end else if (accept_i) begin
            cnt_q  <= cnt_q + 2'd1;
            word_q <= word_o[23:0];
        end
    end

endmodule

// File: rtl/mips32_prog_loader.sv
// Boot loader for the mips32 core: receives a header plus data words over a byte stream,
// writes them into core memory and releases the core with a one-cycle start pulse.
module mips32_prog_loader
    import mips32_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 1024
) (
    input  logic                 clk1,
    input  logic                 rst,
    mips32_prog_loader_if.master bus
);

    loader_state_t        state_q, state_d;
    logic [LDR_CNT_W-1:0] base_q, base_d;
    logic [LDR_CNT_W-1:0] count_q, count_d;
    logic [LDR_CNT_W-1:0] wl_q, wl_d;
    logic                 mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]    mem_wdata_q, mem_wdata_d;
    logic                 in_ready_q, in_ready_d;
    logic                 busy_q, cpu_hold_q, cpu_start_q, done_q, err_q;

    logic                 word_valid;
    logic [31:0]          word;
    logic [LDR_CNT_W-1:0] hdr_base, hdr_count;
    logic [LDR_CNT_W:0]   hdr_end;

    // Any state change drops a partial word so every phase starts on a word boundary.
    mips32_byte_packer u_packer (
        .clk1         (clk1),
        .clear_i      (rst || (state_d != state_q)),
        .accept_i     (bus.in_valid && in_ready_q),
        .byte_i       (bus.in_data),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

    assign hdr_base  = word[LDR_HDR_BASE_MSB:LDR_HDR_BASE_LSB];
    assign hdr_count = word[LDR_HDR_COUNT_MSB:LDR_HDR_COUNT_LSB];
    assign hdr_end   = {1'b0, hdr_base} + {1'b0, hdr_count};

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        count_d     = count_q;
        wl_d        = wl_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            HDR: begin
                if (word_valid) begin
                    wl_d = '0;
                    if (hdr_count == '0) begin
                        state_d = START;
                    end else if (hdr_end > (LDR_CNT_W+1)'(MEM_DEPTH)) begin
                        state_d = ERR;
                    end else begin
                        base_d  = hdr_base;
                        count_d = hdr_count;
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                // The final write is still on the bus when words_loaded reaches count.
                if (wl_q == count_q) begin
                    state_d = START;
                end else if (word_valid) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = ADDR_W'(base_q + wl_q);
                    mem_wdata_d = DATA_W'(word);
                    wl_d        = wl_q + 1'b1;
                end
            end
            START:     state_d = DONE;
            DONE, ERR: if (bus.load_req) state_d = HDR;
            default:   state_d = HDR;
        endcase
        in_ready_d = (state_d == HDR) || ((state_d == DATA) && (wl_d != count_d));
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            state_q     <= HDR;
            base_q      <= '0;
            count_q     <= '0;
            wl_q        <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            cpu_hold_q  <= 1'b1;
            cpu_start_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            count_q     <= count_d;
            wl_q        <= wl_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= (state_d == HDR) || (state_d == DATA);
            cpu_hold_q  <= !((state_d == START) || (state_d == DONE));
            cpu_start_q <= (state_d == START);
            done_q      <= (state_d == DONE);
            err_q       <= (state_d == ERR);
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.mem_we       = mem_we_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_wdata    = mem_wdata_q;
    assign bus.cpu_hold     = cpu_hold_q;
    assign bus.cpu_start    = cpu_start_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.err          = err_q;
    assign bus.words_loaded = wl_q;
    assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_mips32_prog_loader.sv
// Self-checking bench for mips32_prog_loader: protocol-level model, write scoreboard,
// directed boot scenarios and randomized loads with random source stalls.
module tb_mips32_prog_loader;
  import mips32_pkg::*;

  localparam int ADDR_W    = 10;
  localparam int DATA_W    = 32;
  localparam int MEM_DEPTH = 1024;

  localparam int PH_HDR = 0, PH_DATA = 1, PH_FLUSH = 2, PH_START = 3, PH_DONE = 4, PH_ERR = 5;

  logic clk1 = 1'b0;
  logic rst;

  mips32_prog_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mips32_prog_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH)) dut (
    .clk1 (clk1),
    .rst  (rst),
    .bus  (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk1 = ~clk1;

  // ---------------- counters, scoreboard, memory image ----------------
  int n_vec = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int start_cnt = 0;
  logic [ADDR_W+31:0] exp_q[$];
  logic [31:0] mem[MEM_DEPTH];
  logic [31:0] snap[11];
  logic [31:0] prog[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (byte-stream protocol level) ----------------
  int ph = PH_HDR;
  int nb = 0;
  int m_base = 0, m_cnt = 0, m_wl = 0;
  logic [31:0] acc = '0;
  bit fresh = 1'b1, started = 1'b0, m_take;
  bit e_ready, e_busy, e_start, e_hold, e_done, e_err, e_we;
  int e_addr;
  logic [31:0] e_data;

  always @(posedge clk1) begin
    m_take = e_ready && bus.in_valid;
    e_we = 1'b0;
    if (rst) begin
      ph = PH_HDR; nb = 0; m_wl = 0; fresh = 1'b1; started = 1'b1;
    end else begin
      fresh = 1'b0;
      case (ph)
        PH_HDR, PH_DATA: if (m_take) begin
          acc = {acc[23:0], bus.in_data};
          nb++;
          if (nb == 4) begin
            nb = 0;
            if (ph == PH_HDR) begin
              m_base = int'(acc[31:16]);
              m_cnt  = int'(acc[15:0]);
              m_wl   = 0;
              if (m_cnt == 0)                        ph = PH_START;
              else if (m_base + m_cnt > MEM_DEPTH)   ph = PH_ERR;
              else                                   ph = PH_DATA;
            end else begin
              e_we   = 1'b1;
              e_addr = (m_base + m_wl) % (1 << ADDR_W);
              e_data = acc;
              m_wl++;
              if (m_wl == m_cnt) ph = PH_FLUSH;
            end
          end
        end
        PH_FLUSH: ph = PH_START;
        PH_START: ph = PH_DONE;
        default:  if (bus.load_req) begin ph = PH_HDR; nb = 0; end
      endcase
    end
    e_ready = !fresh && (ph == PH_HDR || ph == PH_DATA);
    e_busy  = !fresh && (ph == PH_HDR || ph == PH_DATA || ph == PH_FLUSH);
    e_start = (ph == PH_START);
    e_hold  = !(ph == PH_START || ph == PH_DONE);
    e_done  = (ph == PH_DONE);
    e_err   = (ph == PH_ERR);
  end

  // ---------------- compare process + write scoreboard ----------------
  always @(negedge clk1) begin
    logic [ADDR_W+31:0] ent;
    if (started) begin
      chk("in_ready", 32'(bus.in_ready), 32'(e_ready));
      chk("busy", 32'(bus.busy), 32'(e_busy));
      chk("cpu_start", 32'(bus.cpu_start), 32'(e_start));
      chk("cpu_hold", 32'(bus.cpu_hold), 32'(e_hold));
      chk("done", 32'(bus.done), 32'(e_done));
      chk("err", 32'(bus.err), 32'(e_err));
      chk("words_loaded", 32'(bus.words_loaded), 32'(m_wl));
      chk("mem_we", 32'(bus.mem_we), 32'(e_we));
      if (e_we) begin
        chk("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
        chk("mem_wdata", bus.mem_wdata, e_data);
      end
      if (bus.cpu_start) start_cnt++;
      if (bus.mem_we) begin
        wr_cnt++;
        mem[bus.mem_addr] = bus.mem_wdata;
        if (exp_q.size() == 0) begin
          chk("sb_stray_write", 32'(bus.mem_addr), 32'hffff_ffff);
        end else begin
          ent = exp_q.pop_front();
          chk("sb_addr", 32'(bus.mem_addr), 32'(ent[ADDR_W+31:32]));
          chk("sb_data", bus.mem_wdata, ent[31:0]);
        end
      end
    end
  end

  // ---------------- driver tasks (all start and end just after a negedge) ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk1);
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int g;
    bit ok;
    g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    repeat (g) @(negedge clk1);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    for (int t = 0; ; t++) begin
      ok = bus.in_ready;
      @(posedge clk1);
      if (ok) break;
      if (t > 50) begin
        chk("handshake_timeout", 32'd1, 32'd0);
        break;
      end
    end
    @(negedge clk1);
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom);
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], max_gap);
  endtask

  task automatic send_load(input int base, input int cnt, input int max_gap);
    send_word({16'(base), 16'(cnt)}, max_gap);
    for (int i = 0; i < prog.size(); i++) begin
      exp_q.push_back({ADDR_W'(base + i), prog[i]});
      send_word(prog[i], max_gap);
    end
  endtask

  task automatic pulse_load_req();
    bus.load_req = 1'b1;
    @(negedge clk1);
    bus.load_req = 1'b0;
  endtask

  task automatic wait_end();
    for (int t = 0; t < 300; t++) begin
      if (bus.done || bus.err) return;
      @(negedge clk1);
    end
    chk("wait_done_timeout", 32'd1, 32'd0);
  endtask

  function automatic void load_factorial();
    prog = '{32'h280a00c8, 32'h0d420000, 32'h0d430001, 32'h28440001, 32'h0c642000,
             32'h3c610000, 32'h10240004, 32'h04430000, 32'h29420001, 32'h08000005,
             32'hfc000000};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int base, cnt, wr0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.load_req = 1'b0;
    tick(3);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_cpu_hold", 32'(bus.cpu_hold), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    tick(1);
    chk("hdr_in_ready", 32'(bus.in_ready), 32'd1);

    // Factorial program, no gaps
    load_factorial();
    start_cnt = 0;
    send_load(0, 11, 0);
    chk("fact_we_latency", 32'(bus.mem_we), 32'd1);
    chk("fact_last_addr", 32'(bus.mem_addr), 32'd10);
    tick(1);
    chk("fact_cpu_start", 32'(bus.cpu_start), 32'd1);
    tick(1);
    chk("fact_done", 32'(bus.done), 32'd1);
    chk("fact_cpu_hold", 32'(bus.cpu_hold), 32'd0);
    chk("fact_words_loaded", 32'(bus.words_loaded), 32'd11);
    chk("fact_start_pulses", 32'(start_cnt), 32'd1);
    chk("fact_mem0", mem[0], 32'h280a00c8);
    chk("fact_mem10", mem[10], 32'hfc000000);
    chk("fact_hlt_opcode", 32'(mem[10][31:26]), 32'(HLT_OPCODE));
    for (int i = 0; i < 11; i++) snap[i] = mem[i];

    // Offset load: one word at address 200
    pulse_load_req();
    prog = '{32'h0000000a};
    send_load(200, 1, 0);
    chk("ofs_addr", 32'(bus.mem_addr), 32'd200);
    chk("ofs_data", bus.mem_wdata, 32'd10);
    wait_end();
    chk("ofs_done", 32'(bus.done), 32'd1);

    // Overflow header 0x03FF0002
    pulse_load_req();
    wr0 = wr_cnt;
    prog.delete();
    send_word(32'h03ff0002, 0);
    chk("ovf_err", 32'(bus.err), 32'd1);
    chk("ovf_in_ready", 32'(bus.in_ready), 32'd0);
    chk("ovf_cpu_hold", 32'(bus.cpu_hold), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hAA;
    tick(4);
    bus.in_valid = 1'b0;
    chk("ovf_no_writes", 32'(wr_cnt - wr0), 32'd0);
    pulse_load_req();
    chk("ovf_err_cleared", 32'(bus.err), 32'd0);
    chk("ovf_back_to_hdr", 32'(bus.in_ready), 32'd1);

    // Zero count
    wr0 = wr_cnt;
    send_word(32'h00000000, 0);
    chk("zero_cpu_start", 32'(bus.cpu_start), 32'd1);
    tick(1);
    chk("zero_done", 32'(bus.done), 32'd1);
    chk("zero_no_writes", 32'(wr_cnt - wr0), 32'd0);

    // Reset mid-word, then a full load at base 16
    pulse_load_req();
    send_word(32'h00100002, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);
    wr0 = wr_cnt;
    prog = '{$urandom, $urandom};
    send_load(16, 2, 0);
    wait_end();
    chk("rstmid_writes", 32'(wr_cnt - wr0), 32'd2);
    chk("rstmid_mem16", mem[16], prog[0]);
    chk("rstmid_mem17", mem[17], prog[1]);

    // Stalled source: factorial again with random 0..5 cycle gaps
    pulse_load_req();
    for (int i = 0; i < 11; i++) mem[i] = '0;
    load_factorial();
    send_load(0, 11, 5);
    wait_end();
    chk("stall_words_loaded", 32'(bus.words_loaded), 32'd11);
    for (int i = 0; i < 11; i++) chk($sformatf("stall_mem%0d", i), mem[i], snap[i]);

    // Randomized loads, including some rejected headers
    for (int k = 0; k < 8; k++) begin
      pulse_load_req();
      if ($urandom_range(3, 0) == 0) begin
        base = int'($urandom_range(1023, 1));
        cnt  = MEM_DEPTH + 1 - base + int'($urandom_range(3, 0));
        prog.delete();
        send_word({16'(base), 16'(cnt)}, 3);
      end else begin
        base = int'($urandom_range(1000, 0));
        cnt  = int'($urandom_range(6, 1));
        prog.delete();
        for (int i = 0; i < cnt; i++) prog.push_back($urandom);
        send_load(base, cnt, 4);
      end
      wait_end();
    end

    tick(5);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
